// File: rtl/bitmanip_issue.sv
// bitmanip_issue: decode/issue stage feeding the bit-manipulation execute unit
module bitmanip_issue #(
    parameter int MUL_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic [20:0] bm_instruction,
    output logic [31:0] bm_rs1,
    output logic [31:0] bm_rs2,
    input  logic [31:0] bm_rd,
    input  logic        bm_done,
    input  logic        bm_busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd_addr,
    output logic        out_illegal,
    output logic        out_timeout
);
    localparam int CW = $clog2(MUL_TIMEOUT);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

    state_t        state_q;
    logic [20:0]   ctrl_q;
    logic [31:0]   rs1_q, rs2_q, res_q;
    logic [4:0]    rd_q;
    logic          illegal_q, timeout_q, valid_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   ops_d;
    logic [20:0]   ctrl_d;
    logic [6:0]    f7;
    logic [2:0]    f3;
    logic          is_op, is_opi;
    logic          unused_bits;

    assign f7          = in_insn[31:25];
    assign f3          = in_insn[14:12];
    assign is_op       = in_insn[6:0] == 7'b0110011;
    assign is_opi      = in_insn[6:0] == 7'b0010011 && f3 == 3'b101;
    assign unused_bits = ^in_insn[19:15];

    // Decode the raw instruction into imm plus one-hot op
    always_comb begin
        ops_d     = '0;
        ops_d[15] = is_op && f7 == 7'b0000101 && f3 == 3'b001;
        ops_d[14] = is_op && f7 == 7'b0000101 && f3 == 3'b011;
        ops_d[13] = is_op && f7 == 7'b0010100 && f3 == 3'b010;
        ops_d[12] = is_op && f7 == 7'b0010100 && f3 == 3'b100;
        ops_d[11] = is_op && f7 == 7'b0110000 && f3 == 3'b101;
        ops_d[10] = is_op && f7 == 7'b0110000 && f3 == 3'b001;
        ops_d[9]  = is_opi && f7 == 7'b0110000;
        ops_d[8]  = is_op && f7 == 7'b0100000 && f3 == 3'b111;
        ops_d[7]  = is_op && f7 == 7'b0100000 && f3 == 3'b110;
        ops_d[6]  = is_op && f7 == 7'b0100000 && f3 == 3'b100;
        ops_d[5]  = is_op && f7 == 7'b0000100 && f3 == 3'b100;
        ops_d[4]  = is_op && f7 == 7'b0100100 && f3 == 3'b100;
        ops_d[3]  = is_op && f7 == 7'b0000100 && f3 == 3'b111;
        ops_d[2]  = is_opi && f7 == 7'b0110100;
        ops_d[1]  = is_op && f7 == 7'b0000100 && f3 == 3'b001;
        ops_d[0]  = is_op && f7 == 7'b0000100 && f3 == 3'b101;
        ctrl_d    = {(ops_d[9] || ops_d[2]) ? in_insn[24:20] : 5'd0, ops_d};
    end

    assign in_ready       = rst && state_q == IDLE && !bm_busy;
    assign bm_instruction = ctrl_q;
    assign bm_rs1         = rs1_q;
    assign bm_rs2         = rs2_q;
    assign out_valid      = valid_q;
    assign out_data       = res_q;
    assign out_rd_addr    = rd_q;
    assign out_illegal    = illegal_q;
    assign out_timeout    = timeout_q;

    // Issue FSM: unit inputs are held only while it is working, zero otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            res_q     <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid && in_ready) begin
                    rd_q <= in_insn[11:7];
                    if (|ops_d) begin
                        ctrl_q  <= ctrl_d;
                        rs1_q   <= in_rs1;
                        rs2_q   <= in_rs2;
                        state_q <= EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        res_q     <= '0;
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                EXEC: if (ctrl_q[15] || ctrl_q[14]) begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end else begin
                    res_q   <= bm_rd;
                    ctrl_q  <= '0;
                    rs1_q   <= '0;
                    rs2_q   <= '0;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                WAIT: if (bm_done || cnt_q == CW'(MUL_TIMEOUT - 1)) begin
                    res_q     <= bm_done ? bm_rd : 32'd0;
                    timeout_q <= !bm_done;
                    ctrl_q    <= '0;
                    rs1_q     <= '0;
                    rs2_q     <= '0;
                    valid_q   <= 1'b1;
                    state_q   <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: if (out_ready) begin
                    valid_q   <= 1'b0;
                    illegal_q <= 1'b0;
                    timeout_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitmanip_issue.sv
// tb_bitmanip_issue: vector table plus scoreboard checks for bitmanip_issue
module tb_bitmanip_issue;
    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid, in_ready, bm_done, bm_busy, out_valid, out_ready;
    logic        out_illegal, out_timeout;
    logic [31:0] in_insn, in_rs1, in_rs2, bm_rs1, bm_rs2, bm_rd, out_data;
    logic [20:0] bm_instruction;
    logic [4:0]  out_rd_addr;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [31:0] insn, rs1, rs2;
        logic [20:0] ctrl;
        logic [31:0] data;
        logic        ill, tmo;
        int          lat;
        logic [31:0] done_mask;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        ill, tmo;
    } exp_t;

    vec_t vt [16];
    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;

    bitmanip_issue #(.MUL_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_insn(in_insn), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .bm_instruction(bm_instruction), .bm_rs1(bm_rs1), .bm_rs2(bm_rs2),
        .bm_rd(bm_rd), .bm_done(bm_done), .bm_busy(bm_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd_addr(out_rd_addr), .out_illegal(out_illegal), .out_timeout(out_timeout)
    );

    function automatic logic [31:0] rotr(input logic [31:0] a, input logic [4:0] s);
        return (a >> s) | (a << (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [63:0] clmul64(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r = '0;
        for (int i = 0; i < 32; i++) if (b[i]) r = r ^ ({32'd0, a} << i);
        return r;
    endfunction

    // Behavioural execute unit; unmodelled ops echo the control word
    always_comb begin
        bm_rd = {11'd0, bm_instruction};
        if (bm_instruction[8])  bm_rd = bm_rs1 & ~bm_rs2;
        if (bm_instruction[7])  bm_rd = bm_rs1 | ~bm_rs2;
        if (bm_instruction[6])  bm_rd = ~(bm_rs1 ^ bm_rs2);
        if (bm_instruction[11]) bm_rd = rotr(bm_rs1, bm_rs2[4:0]);
        if (bm_instruction[10]) bm_rd = rotr(bm_rs1, 5'd0 - bm_rs2[4:0]);
        if (bm_instruction[9])  bm_rd = rotr(bm_rs1, bm_instruction[20:16]);
        if (bm_instruction[5])  bm_rd = {bm_rs2[15:0], bm_rs1[15:0]};
        if (bm_instruction[15]) bm_rd = clmul64(bm_rs1, bm_rs2)[31:0];
        if (bm_instruction[14]) bm_rd = clmul64(bm_rs1, bm_rs2)[63:32];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop and compare on every writeback handshake
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got result %h expected none", out_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, e.rd});
                chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                chk("out_timeout", {31'd0, out_timeout}, {31'd0, e.tmo});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drive(input vec_t v, input bit push);
        wait_ready();
        in_insn  = v.insn;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
        in_valid = 1'b1;
        if (push) sb.push_back('{v.data, v.insn[11:7], v.ill, v.tmo});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_insn  = '0;
        in_rs1   = '0;
        in_rs2   = '0;
    endtask

    task automatic run(input vec_t v);
        int lat = 0;
        bit seen = 0, held = 1;
        drive(v, 1'b1);
        while (!seen && lat < 40) begin
            lat++;
            bm_done = lat < 32 ? v.done_mask[lat] : 1'b0;
            @(negedge clk);
            if (lat == 1) begin
                chk("bm_ctrl_exec", {11'd0, bm_instruction}, v.ill ? 32'd0 : {11'd0, v.ctrl});
                chk("bm_rs1_exec", bm_rs1, v.ill ? 32'd0 : v.rs1);
                chk("bm_rs2_exec", bm_rs2, v.ill ? 32'd0 : v.rs2);
            end else if (!out_valid && bm_instruction !== v.ctrl) held = 0;
            if (out_valid) begin
                seen = 1;
                chk("latency", 32'(lat), 32'(v.lat));
                chk("bm_ctrl_done", {11'd0, bm_instruction}, 32'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        bm_done = 1'b0;
        if (!seen) chk("out_valid_timeout", 32'(lat), 32'(v.lat));
        if (v.lat > 2) chk("bm_ctrl_held", {31'd0, held}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_bm_ctrl"}, {11'd0, bm_instruction}, 32'd0);
        chk({tag, "_bm_rs1"}, bm_rs1, 32'd0);
        chk({tag, "_bm_rs2"}, bm_rs2, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_rd"}, {27'd0, out_rd_addr}, 32'd0);
        chk({tag, "_out_ill"}, {31'd0, out_illegal}, 32'd0);
        chk({tag, "_out_tmo"}, {31'd0, out_timeout}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0]  = '{32'h4020F1B3, 32'hFFFF0000, 32'h0F0F0F0F, 21'h00100, 32'hF0F00000, 1'b0, 1'b0, 2, 32'h6};
        vt[1]  = '{32'h6080D293, 32'h12345678, 32'h00000000, 21'h80200, 32'h78123456, 1'b0, 1'b0, 2, 32'h0};
        vt[2]  = '{32'h0A209233, 32'h00000003, 32'h00000003, 21'h08000, 32'h00000005, 1'b0, 1'b0, 8, 32'h80};
        vt[3]  = '{32'h00000013, 32'h11111111, 32'h22222222, 21'h00000, 32'h00000000, 1'b1, 1'b0, 1, 32'h0};
        vt[4]  = '{32'h0A209233, 32'h00000003, 32'h00000003, 21'h08000, 32'h00000000, 1'b0, 1'b1, 18, 32'h0};
        vt[5]  = '{32'h4020E333, 32'h0000FFFF, 32'h00FF00FF, 21'h00080, 32'hFF00FFFF, 1'b0, 1'b0, 2, 32'h0};
        vt[6]  = '{32'h4020C3B3, 32'hAAAA5555, 32'hA5A5A5A5, 21'h00040, 32'hF0F00F0F, 1'b0, 1'b0, 2, 32'h0};
        vt[7]  = '{32'h60209433, 32'h80000001, 32'h00000004, 21'h00400, 32'h00000018, 1'b0, 1'b0, 2, 32'h0};
        vt[8]  = '{32'h6020D4B3, 32'h80000001, 32'h00000024, 21'h00800, 32'h18000000, 1'b0, 1'b0, 2, 32'h0};
        vt[9]  = '{32'h0820C533, 32'h1234ABCD, 32'h5678EF01, 21'h00020, 32'hEF01ABCD, 1'b0, 1'b0, 2, 32'h0};
        vt[10] = '{32'h6980D593, 32'h00000001, 32'h00000000, 21'h180004, 32'h00180004, 1'b0, 1'b0, 2, 32'h0};
        vt[11] = '{32'h2820A633, 32'h00000000, 32'h00000000, 21'h02000, 32'h00002000, 1'b0, 1'b0, 2, 32'h0};
        vt[12] = '{32'h082096B3, 32'h00000000, 32'h00000000, 21'h00002, 32'h00000002, 1'b0, 1'b0, 2, 32'h0};
        vt[13] = '{32'h0A208733, 32'h00000005, 32'h00000006, 21'h00000, 32'h00000000, 1'b1, 1'b0, 1, 32'h0};
        vt[14] = '{32'h60809793, 32'h00000005, 32'h00000006, 21'h00000, 32'h00000000, 1'b1, 1'b0, 1, 32'h0};
        vt[15] = '{32'h0A20B833, 32'h80000000, 32'h80000000, 21'h04000, 32'h40000000, 1'b0, 1'b0, 5, 32'h12};
        in_valid = 1'b0; in_insn = '0; in_rs1 = '0; in_rs2 = '0;
        bm_done = 1'b0; bm_busy = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        bm_busy = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        bm_busy = 1'b0;
        #1 chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 16; i++) run(vt[i]);
        out_ready = 1'b0;
        drive(vt[0], 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
            chk("bp_data_hold", out_data, 32'hF0F00000);
            chk("bp_rd_hold", {27'd0, out_rd_addr}, 32'd3);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("bp_released", {31'd0, out_valid}, 32'd0);
        drive(vt[2], 1'b0);
        repeat (3) @(negedge clk);
        chk("wait_ctrl", {11'd0, bm_instruction}, 32'h08000);
        rst = 1'b0;
        #1 chk_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("sb_empty_rst", 32'(sb.size()), 32'd0);
        run(vt[1]);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
